// File: rtl/systolic_feeder.sv
// Operand feeder for a DIM x DIM systolic PE grid.
// Holds matrices A and B, then streams them as skewed row/column lanes
// so that A[i][k] and B[k][j] meet at PE(i,j) on the same cycle.
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic                        wr_sel_i,
    input  logic [IDX_WIDTH-1:0]        wr_row_i,
    input  logic [IDX_WIDTH-1:0]        wr_col_i,
    input  logic [DATA_WIDTH-1:0]       wr_data_i,
    input  logic                        go_i,
    input  logic                        clear_i,
    output logic [DIM*DATA_WIDTH-1:0]   a_o,
    output logic [DIM*DATA_WIDTH-1:0]   b_o,
    output logic                        start_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned LANES_W = DIM * DATA_WIDTH;
    localparam int unsigned T_LAST  = 3 * DIM - 3;
    localparam int unsigned T_W     = $clog2(3 * DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [T_W-1:0] t_q, t_d;

    logic [DATA_WIDTH-1:0] mem_a [DIM][DIM];
    logic [DATA_WIDTH-1:0] mem_b [DIM][DIM];

    logic               wr_ok;
    logic [LANES_W-1:0] a_d;
    logic [LANES_W-1:0] b_d;
    logic               start_d;
    logic               busy_d;
    logic               done_d;

    // Writes land only in IDLE; a same-edge go wins and the write is lost.
    assign wr_ok = (state_q == S_IDLE) && wr_en_i && !go_i;

    // State and step counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next-state and step counter logic.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    state_d = S_STREAM;
                    t_d     = '0;
                end
            end
            S_STREAM: begin
                if (t_q == T_W'(T_LAST)) begin
                    state_d = S_DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_DONE: begin
                if (clear_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state and step.
    always_comb begin
        a_d     = '0;
        b_d     = '0;
        start_d = (state_d != S_IDLE);
        busy_d  = (state_d == S_STREAM);
        done_d  = (state_d == S_DONE);
        if (state_d == S_STREAM) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = 0; k < DIM; k++) begin
                    if (int'(t_d) == i + k) begin
                        a_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_a[i][k];
                        b_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_b[k][i];
                    end
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_o     <= '0;
            b_o     <= '0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            a_o     <= a_d;
            b_o     <= b_d;
            start_o <= start_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
        end
    end

    // Operand storage; out-of-range indices match no entry and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mem_a[r][c] <= '0;
                    mem_b[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (wr_row_i == IDX_WIDTH'(r) && wr_col_i == IDX_WIDTH'(c)) begin
                        if (!wr_sel_i) begin
                            mem_a[r][c] <= wr_data_i;
                        end else begin
                            mem_b[r][c] <= wr_data_i;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder with a behavioural PE grid downstream.
module tb_systolic_feeder;

    localparam int DW    = 8;
    localparam int DIM   = 4;
    localparam int IW    = 3;
    localparam int NSTEP = 3 * DIM - 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              wr_en, wr_sel, go, clr;
    logic [IW-1:0]     wr_row, wr_col;
    logic [DW-1:0]     wr_data;
    logic [DIM*DW-1:0] a_o, b_o;
    logic              start_o, busy_o, done_o;

    systolic_feeder #(.DATA_WIDTH(DW), .DIM(DIM), .IDX_WIDTH(IW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_row_i(wr_row), .wr_col_i(wr_col), .wr_data_i(wr_data),
        .go_i(go), .clear_i(clr), .a_o(a_o), .b_o(b_o),
        .start_o(start_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DIM*DW-1:0] a;
        logic [DIM*DW-1:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic signed [DW-1:0] ma [DIM][DIM];
    logic signed [DW-1:0] mb [DIM][DIM];
    logic m_idle = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected lanes for one full stream straight from the skew rule.
    task automatic push_stream();
        exp_t e;
        int k;
        for (int t = 0; t < NSTEP; t++) begin
            e = '0;
            for (int i = 0; i < DIM; i++) begin
                k = t - i;
                if (k >= 0 && k < DIM) begin
                    e.a[i*DW +: DW] = ma[i][k];
                    e.b[i*DW +: DW] = mb[k][i];
                end
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic do_write(input logic sel, input int row, input int col, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_row = IW'(row); wr_col = IW'(col); wr_data = data;
        if (m_idle && !go && row < DIM && col < DIM) begin
            if (!sel) ma[row][col] = data; else mb[row][col] = data;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_go();
        go = 1'b1;
        if (m_idle) begin
            push_stream();
            m_idle = 1'b0;
        end
        busy_cnt = 0;
        step();
        go = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk({name, "_done"}, 64'(done_o), 64'(1));
        chk({name, "_start"}, 64'(start_o), 64'(1));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(NSTEP));
        chk({name, "_done_lanes"}, 64'({a_o, b_o}), 64'(0));
        chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
        m_idle = 1'b1;
        chk("clear_start", 64'(start_o), 64'(0));
        chk("clear_state", 64'({busy_o, done_o}), 64'(0));
    endtask

    // Monitor: every streaming cycle pops one expected lane set.
    always @(negedge clk) begin
        if (rst_ni === 1'b1 && busy_o === 1'b1) begin
            busy_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_busy: busy_o=1 with no expected stream step");
            end else begin
                mon_e = sb_q.pop_front();
                chk("a_lanes", 64'(a_o), 64'(mon_e.a));
                chk("b_lanes", 64'(b_o), 64'(mon_e.b));
            end
        end
    end

    // Behavioural output-stationary PE grid: a moves right, b moves down.
    int acc [DIM][DIM];
    logic signed [DW-1:0] ar [DIM][DIM];
    logic signed [DW-1:0] br [DIM][DIM];

    function automatic logic signed [DW-1:0] gin_a(input int i, input int j);
        if (j == 0) return a_o[i*DW +: DW];
        return ar[i][j-1];
    endfunction

    function automatic logic signed [DW-1:0] gin_b(input int i, input int j);
        if (i == 0) return b_o[j*DW +: DW];
        return br[i-1][j];
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    acc[i][j] <= 0; ar[i][j] <= '0; br[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    ar[i][j] <= gin_a(i, j);
                    br[i][j] <= gin_b(i, j);
                    acc[i][j] <= start_o ? acc[i][j] + int'(gin_a(i, j)) * int'(gin_b(i, j)) : 0;
                end
        end
    end

    task automatic check_grid(input string name);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                chk({name, "_pe"}, 64'(acc[i][j]), 64'(int'(mb[i][j])));
                chk({name, "_ovf"}, 64'(acc[i][j] > 32767 || acc[i][j] < -32768), 64'(0));
            end
    endtask

    initial begin
        rst_ni = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0;
        wr_data = '0; go = 1'b0; clr = 1'b0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = '0; mb[i][j] = '0;
            end
        step();
        step();
        chk("rst_a", 64'(a_o), 64'(0));
        chk("rst_b", 64'(b_o), 64'(0));
        chk("rst_flags", 64'({start_o, busy_o, done_o}), 64'(0));
        rst_ni = 1'b1;
        step();

        // Skew pattern
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                do_write(1'b0, i, k, DW'(16 * i + k));
                do_write(1'b1, i, k, DW'(16 * i + k));
            end
        do_go();
        wait_done("skew");
        do_clear();

        // Write while busy is dropped; replay shows original operands
        do_go();
        step();
        do_write(1'b0, 0, 0, 8'h7F);
        wait_done("busy_wr");
        do_clear();
        do_go();
        wait_done("replay");

        // go and clear together in DONE: clear wins, no new stream
        go = 1'b1; clr = 1'b1;
        step();
        go = 1'b0; clr = 1'b0;
        m_idle = 1'b1;
        chk("goclr_start", 64'(start_o), 64'(0));
        chk("goclr_state", 64'({busy_o, done_o}), 64'(0));
        step();
        step();
        chk("goclr_idle", 64'({start_o, busy_o, done_o}), 64'(0));

        // End to end: identity times signed B
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                do_write(1'b0, i, j, (i == j) ? DW'(1) : DW'(0));
                do_write(1'b1, i, j, DW'(i - j));
            end
        do_go();
        wait_done("e2e");
        check_grid("e2e");
        step();
        step();
        check_grid("e2e_hold");
        do_clear();

        // Bad indices and a write colliding with go are dropped
        do_write(1'b0, 5, 1, 8'h55);
        do_write(1'b1, 2, 6, 8'h66);
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = IW'(1); wr_col = IW'(1); wr_data = 8'h11;
        do_go();
        wr_en = 1'b0;
        wait_done("badidx");
        do_clear();

        // Randomised rounds including out-of-range writes
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    do_write(1'b0, i, j, DW'($urandom));
                    do_write(1'b1, i, j, DW'($urandom));
                end
            for (int n = 0; n < 6; n++)
                do_write(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), DW'($urandom));
            do_go();
            wait_done("rand");
            do_clear();
        end

        // Reset mid-stream at t=4, then an immediate go streams zeros
        do_go();
        repeat (4) step();
        rst_ni = 1'b0;
        #1;
        chk("midrst_lanes", 64'({a_o, b_o}), 64'(0));
        chk("midrst_flags", 64'({start_o, busy_o, done_o}), 64'(0));
        sb_q.delete();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = '0; mb[i][j] = '0;
            end
        m_idle = 1'b1;
        @(negedge clk);
        chk("midrst_nodone", 64'(done_o), 64'(0));
        rst_ni = 1'b1;
        do_go();
        wait_done("post_rst");
        do_clear();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits (signed two's complement).
REQ-002 SHALL have parameter DIM, default 4, matrix dimension and PE grid edge length (2..8).
REQ-003 SHALL have parameter IDX_WIDTH, default 3, width of the row and column index ports (at least clog2(DIM)).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en_i, input, 1, operand write strobe.
REQ-007 SHALL have port wr_sel_i, input, 1, write target: 0 = matrix A, 1 = matrix B.
REQ-008 SHALL have ports wr_row_i and wr_col_i, input, IDX_WIDTH each, element row and column index.
REQ-009 SHALL have port wr_data_i, input, DATA_WIDTH, signed element value.
REQ-010 SHALL have port go_i, input, 1, request to start streaming.
REQ-011 SHALL have port clear_i, input, 1, releases a finished result and clears the PE grid.
REQ-012 SHALL have port a_o, output, DIM*DATA_WIDTH, row-lane operands; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH] and feeds grid row i.
REQ-013 SHALL have port b_o, output, DIM*DATA_WIDTH, column-lane operands; lane j feeds grid column j.
REQ-014 SHALL have port start_o, output, 1, the grid start/accumulate-enable.
REQ-015 SHALL have port busy_o, output, 1, high in STREAM state.
REQ-016 SHALL have port done_o, output, 1, high in DONE state.

Function
REQ-017 SHALL hold two DIM x DIM register arrays, A and B, for operand storage.
REQ-018 SHALL write wr_data_i into A[wr_row_i][wr_col_i] (wr_sel_i=0) or B[wr_row_i][wr_col_i] (wr_sel_i=1) on the rising edge where wr_en_i=1, but only in IDLE.
REQ-019 SHALL silently drop writes made in STREAM or DONE, and writes with either index >= DIM.
REQ-020 SHALL implement three states: IDLE, STREAM and DONE.
REQ-021 SHALL move IDLE -> STREAM when go_i=1 is sampled in IDLE, and SHALL clear the step counter t to 0 on that transition.
REQ-022 SHALL give go_i priority over a same-edge write, which is dropped.
REQ-023 SHALL hold STREAM for exactly 3*DIM-2 cycles (t = 0 .. 3*DIM-3), incrementing t once per cycle, then move to DONE.
REQ-024 SHALL, in STREAM at step t, drive a_o lane i = A[i][t-i] when 0 <= t-i < DIM, else 0.
REQ-025 SHALL, in STREAM at step t, drive b_o lane j = B[t-j][j] when 0 <= t-j < DIM, else 0.
REQ-026 SHALL register all outputs, so the t=0 values appear in the first cycle after the edge that samples go_i.
REQ-027 SHALL drive start_o high throughout STREAM and DONE, with a_o = b_o = 0 in DONE so the accumulated grid results stay constant.
REQ-028 SHALL move DONE -> IDLE when clear_i=1 is sampled, driving start_o low from the next cycle so the grid accumulators clear.
REQ-029 SHALL ignore go_i in STREAM and DONE; clear_i wins when go_i and clear_i are both high in DONE.
REQ-030 SHALL ignore clear_i in IDLE and STREAM.
REQ-031 SHALL keep A and B contents across DONE -> IDLE, so go_i alone replays the same operands.
REQ-032 SHALL pass operand values bit-exact with no arithmetic; sign is preserved.

Reset
REQ-033 SHALL, while rst_ni=0, asynchronously force state IDLE, t=0, a_o=0, b_o=0, start_o=0, busy_o=0, done_o=0, and all A/B entries to 0.
REQ-034 SHALL on reset mid-STREAM abort immediately with no done_o pulse, and SHALL accept a fresh go_i in the first cycle after release.

Verification
REQ-035 SHALL test skew, DIM=4: A[i][k]=16*i+k, B[k][j]=16*k+j, go_i -> step 0 a_o=(0,0,0,0x00), step 3 a lanes=(0x30,0x21,0x12,0x03), step 6 lane3=0x33, all other lanes 0; busy_o high for exactly 10 cycles, then done_o=1.
REQ-036 SHALL test end to end with a 4x4 PE grid, A=identity, B[k][j]=k-j (negatives included) -> in DONE every PE result equals B[i][j], overflow 0.
REQ-037 SHALL test write while busy: write A[0][0]=0x7F during STREAM, then clear_i and replay -> replay streams the original A[0][0].
REQ-038 SHALL test clear and go together: go_i=1 and clear_i=1 in DONE -> next state IDLE, start_o=0 for one cycle, no stream starts.
REQ-039 SHALL test reset mid-stream: assert rst_ni=0 at t=4 -> all outputs 0 at once, A/B read back 0 on the next replay (all lanes 0 for 10 cycles).
REQ-040 SHALL test bad index: a write with wr_row_i=5 when DIM=4 -> no array entry changes.
